// File: rtl/fft_twiddle_seq.sv
// Twiddle-coefficient sequencer: streams P coefficients W_N^k per beat, stage by stage, over valid/ready.
// Define TWIDDLE_CONJ_EN to conjugate the coefficients of frames started with inverse=1 (IFFT).
module fft_twiddle_seq #(
    parameter int NBITS = 9,
    parameter int N     = 16,
    parameter int P     = 4,
    parameter int LOG2N = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   inverse,
    input  logic                   coeff_ready,
    output logic                   coeff_valid,
    output logic [P*2*NBITS-1:0]   coeff_data,
    output logic [LOG2N-1:0]       stage,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int HALF = N / 2;
    localparam int B    = N / (2 * P);
    localparam int BW   = (B > 1) ? $clog2(B) : 1;
    localparam int KW   = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int WW   = 2 * NBITS;
    localparam int DW   = P * WW;

    localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
    localparam logic [BW-1:0]    LAST_BEAT  = BW'(B - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state, state_next;
    logic [BW-1:0]     beat, beat_next;
    logic [LOG2N-1:0]  stg_next;
    logic              valid_next;
    logic              load_out;
    logic              clear_out;
    logic              xfer;
    logic              last;
    logic              inv_q;
    logic [DW-1:0]     data_next;
    logic [KW-1:0]     idx;
    logic [WW-1:0]     word;
    logic [WW-1:0]     rom [HALF];

    // Round half away from zero, then clamp into the signed NBITS range.
    function automatic int round_sat(input real x);
        int v;
        int lim;
        lim = (1 << (NBITS - 1)) - 1;
        v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        if (v > lim) v = lim;
        if (v < -lim - 1) v = -lim - 1;
        return v;
    endfunction

    function automatic logic [WW-1:0] twiddle(input int k);
        real ang;
        real amp;
        int  re;
        int  im;
        amp = real'(1 << (NBITS - 2));
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
        re  = round_sat(amp * $cos(ang));
        im  = round_sat(-amp * $sin(ang));
        return {NBITS'(re), NBITS'(im)};
    endfunction

    function automatic logic [KW-1:0] lane_index(input logic [BW-1:0] b, input logic [LOG2N-1:0] s,
                                                 input int l);
        int unsigned j;
        j = ((32'(b) * P) + l) << s;
        return KW'(j & (HALF - 1));
    endfunction

    // The coefficient table is fixed at elaboration; synthesis folds it into constants.
    for (genvar k = 0; k < HALF; k++) begin : g_rom
        assign rom[k] = twiddle(k);
    end

    assign xfer       = coeff_valid & coeff_ready;
    assign last       = (stage == LAST_STAGE) && (beat == LAST_BEAT);
    assign frame_done = xfer & last;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Counters always name the beat being presented; they advance only on a transfer.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        stg_next   = stage;
        valid_next = coeff_valid;
        load_out   = 1'b0;
        clear_out  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    beat_next  = '0;
                    stg_next   = '0;
                end
            end
            LOAD: begin
                state_next = RUN;
                valid_next = 1'b1;
                load_out   = 1'b1;
            end
            RUN: begin
                if (xfer) begin
                    if (last) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        beat_next  = '0;
                        stg_next   = '0;
                        clear_out  = 1'b1;
                    end else begin
                        if (beat == LAST_BEAT) begin
                            beat_next = '0;
                            stg_next  = stage + 1'b1;
                        end else begin
                            beat_next = beat + 1'b1;
                        end
                        load_out = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Coefficients for the next beat, looked up ahead so the output register loads them on transfer.
    always_comb begin
        data_next = '0;
        idx       = '0;
        word      = '0;
        for (int l = 0; l < P; l++) begin
            idx  = lane_index(beat_next, stg_next, l);
            word = rom[idx];
`ifdef TWIDDLE_CONJ_EN
            if (inv_q) begin
                if (word[NBITS-1:0] == {1'b1, {(NBITS-1){1'b0}}})
                    word[NBITS-1:0] = {1'b0, {(NBITS-1){1'b1}}};
                else
                    word[NBITS-1:0] = -word[NBITS-1:0];
            end
`endif
            data_next[l*WW +: WW] = word;
        end
    end

`ifndef TWIDDLE_CONJ_EN
    logic unused_inverse;
    assign unused_inverse = inv_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_valid <= 1'b0;
            coeff_data  <= '0;
            stage       <= '0;
            beat        <= '0;
            inv_q       <= 1'b0;
        end else begin
            coeff_valid <= valid_next;
            stage       <= stg_next;
            beat        <= beat_next;
            if (load_out)
                coeff_data <= data_next;
            else if (clear_out)
                coeff_data <= '0;
            if (state == IDLE && start)
                inv_q <= inverse;
        end
    end

endmodule
